// File: rtl/parity_frame_rx_pkg.sv
// parity_frame_rx_pkg: shared FSM state encodings and frame-format constants for parity_frame_rx.
//   ST_IDLE..ST_STOP : 3-bit state encodings
//   START_LVL        : line level of a start bit
//   STOP_LVL         : line level of a stop bit
//   parity_mismatch  : 1 when accumulated data parity, parity bit and parity sense disagree
package parity_frame_rx_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  function automatic logic parity_mismatch(input logic acc, input logic p, input logic odd);
    return acc ^ p ^ odd;
  endfunction
endpackage

// File: rtl/parity_frame_rx_sync2.sv
// rx_sync2: two-flop synchronizer for the serial line; resets to the idle (high) level.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d_i   in  asynchronous input
//   q_o   out synchronized output
module rx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d_i};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end
  assign q_o = sync_q[1];
endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver (start, DATA_W bits LSB-first, parity, stop) with XOR parity check.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx_i         in   serial line, idles high
//   data_o       out  last received data word (held)
//   valid_o      out  one-cycle pulse per completed frame
//   parity_err_o out  parity mismatch on last frame (held)
//   frame_err_o  out  stop bit sampled low on last frame (held)
//   busy_o       out  high while a frame is being received
//   Define RX_SYNC_EN to insert a 2-flop synchronizer on rx_i (adds 2 clk of latency).
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic          ODD      = (ODD_PARITY != 0);

  logic rx;
`ifdef RX_SYNC_EN
  rx_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d_i(rx_i), .q_o(rx));
`else
  assign rx = rx_i;
`endif

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              acc_q, acc_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              done_q, done_d;
  logic              rx_prev_q, rx_prev_d;
  logic              tick;

  assign tick = (clk_cnt_q == FULL_M1);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = tick ? '0 : clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    rx_prev_d = rx;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev_q && rx == START_LVL) state_d = ST_START;
      end
      ST_START: begin
        // Half a bit in: re-check the start level so short glitches are rejected.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          acc_d     = 1'b0;
          state_d   = (rx == START_LVL) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (tick) begin
          // Bits arrive LSB first, so each new bit enters at the top and walks down.
          shift_d   = DATA_W'({rx, shift_q} >> 1);
          acc_d     = acc_q ^ rx;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          perr_d  = parity_mismatch(acc_q, rx, ODD);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          ferr_d  = (rx != STOP_LVL);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      acc_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;

  // Results publish one cycle after the stop-bit sample, and only then.
  always_comb begin
    valid_d      = done_q;
    data_d       = done_q ? shift_q : data_q;
    parity_err_d = done_q ? perr_q  : parity_err_q;
    frame_err_d  = done_q ? ferr_q  : frame_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed + random frames into an even- and an odd-parity receiver sharing one line.
module tb_parity_frame_rx;
  localparam int W    = 8;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // Cycles from driving the start bit to valid_o: detect edge, half bit, W data + parity + stop bits, publish.
  localparam int LAT = 2 + HALF + (W + 2) * CPB + SYNC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx = 1'b1;
  logic [W-1:0] data_e, data_x;
  logic valid_e, valid_x, perr_e, perr_x, ferr_e, ferr_x, busy_e, busy_x;

  parity_frame_rx #(.DATA_W(W), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .data_o(data_e), .valid_o(valid_e),
    .parity_err_o(perr_e), .frame_err_o(ferr_e), .busy_o(busy_e));
  parity_frame_rx #(.DATA_W(W), .CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .data_o(data_x), .valid_o(valid_x),
    .parity_err_o(perr_x), .frame_err_o(ferr_x), .busy_o(busy_x));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] data_x;
    logic perr_e;
    logic perr_o;
    logic ferr;
    logic ferr_x;
    logic both_v;
    int cyc;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  rec_t mon_r;
  rec_t last_e;
  int compared = 0;
  int mismatched = 0;

  always @(negedge clk) begin
    if (valid_e || valid_x) begin
      mon_r.data = data_e; mon_r.data_x = data_x;
      mon_r.perr_e = perr_e; mon_r.perr_o = perr_x;
      mon_r.ferr = ferr_e; mon_r.ferr_x = ferr_x;
      mon_r.both_v = valid_e & valid_x; mon_r.cyc = cyc;
      obs_q.push_back(mon_r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop, input int gap_bits);
    rec_t e;
    e.data = d; e.data_x = d;
    e.perr_e = ^d ^ p;
    e.perr_o = ~(^d ^ p);
    e.ferr = ~stop; e.ferr_x = ~stop;
    e.both_v = 1'b1;
    e.cyc = cyc + LAT;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    repeat (gap_bits) send_bit(1'b1);
  endtask

  task automatic check_frames(input string tag);
    rec_t o, e;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data_even"}, 32'(o.data), 32'(e.data));
      chk({tag, "_data_odd"}, 32'(o.data_x), 32'(e.data));
      chk({tag, "_perr_even"}, 32'(o.perr_e), 32'(e.perr_e));
      chk({tag, "_perr_odd"}, 32'(o.perr_o), 32'(e.perr_o));
      chk({tag, "_ferr_even"}, 32'(o.ferr), 32'(e.ferr));
      chk({tag, "_ferr_odd"}, 32'(o.ferr_x), 32'(e.ferr));
      chk({tag, "_valid_both"}, 32'(o.both_v), 32'd1);
      chk({tag, "_latency"}, o.cyc, e.cyc);
      last_e = e;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outputs(input string tag, input logic [W-1:0] d, input logic pe, input logic po,
                             input logic fe, input logic busy);
    chk({tag, "_data_even"}, 32'(data_e), 32'(d));
    chk({tag, "_data_odd"}, 32'(data_x), 32'(d));
    chk({tag, "_perr_even"}, 32'(perr_e), 32'(pe));
    chk({tag, "_perr_odd"}, 32'(perr_x), 32'(po));
    chk({tag, "_ferr"}, 32'({ferr_e, ferr_x}), {30'd0, fe, fe});
    chk({tag, "_valid"}, 32'({valid_e, valid_x}), 32'd0);
    chk({tag, "_busy"}, 32'({busy_e, busy_x}), {30'd0, busy, busy});
  endtask

  initial begin
    logic [W-1:0] d;
    logic p, s;
    int g;
    #1 rst_n = 1'b0;
    #2 chk_outputs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    send_frame(8'hA5, 1'b0, 1'b1, 2);
    check_frames("t1_a5");
    chk_outputs("t1_after", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);

    send_frame(8'h3C, 1'b1, 1'b1, 2);
    check_frames("t2_3c");

    send_frame(8'h81, 1'b0, 1'b0, 0);
    repeat (40 * CPB) @(posedge clk);
    #1;
    check_frames("t3_break");
    chk_outputs("t3_held", 8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
    check_frames("t3_rearm_quiet");
    send_frame(8'h5A, 1'b0, 1'b1, 2);
    check_frames("t3_rearm");

    rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("t4_busy_during", 32'({busy_e, busy_x}), 32'd3);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
    check_frames("t4_glitch");
    chk_outputs("t4_after", last_e.data, last_e.perr_e, last_e.perr_o, last_e.ferr, 1'b0);

    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk_outputs("t5_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
    check_frames("t5_aborted");
    send_frame(8'h12, 1'b0, 1'b1, 2);
    check_frames("t5_12");

    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 1);
    check_frames("t6_b2b");

    for (int n = 0; n < 16; n++) begin
      d = W'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      g = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, p, s, g);
    end
    check_frames("rand");
    chk("rand_busy_end", 32'({busy_e, busy_x}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
